dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory load/store traffic, with a valid/ready handshake on both the request and response channels.
- Holds a byte-enabled word RAM, clears it at reset with an address sweep, and inserts a programmable number of wait states per access.
- Lets the core and its load/store unit be exercised against a multi-cycle memory with backpressure, instead of the single-cycle DM.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: byte-enabled word RAM behind valid/ready
// request/response channels, cleared by an address sweep after reset.

module dmem_lane #(
  parameter int ADDR_WIDTH = 10,
  parameter int VEC_W      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] widx,
  input  logic [VEC_W-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] ridx,
  output logic [VEC_W-1:0]      rdata
);
  logic [VEC_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];
endmodule

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  typedef struct packed {
    logic                                we;
    logic [ADDR_WIDTH-1:0]               idx;
    logic [NUM_LANES-1:0]                be;
    logic [NUM_LANES-1:0][VEC_W-1:0]     wdata;
    logic                                err;
  } req_t;

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           clr_idx_q, clr_idx_d;
  logic [3:0]                      wcnt_q, wcnt_d;
  req_t                            req_q, req_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic                            rerr_q, rerr_d;

  logic [NUM_LANES-1:0]            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_widx;
  logic [NUM_LANES-1:0][VEC_W-1:0] mem_wdata;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_word;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_lane #(.ADDR_WIDTH(ADDR_WIDTH), .VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .we    (mem_we[l]),
      .widx  (mem_widx),
      .wdata (mem_wdata[l]),
      .ridx  (req_q.idx),
      .rdata (rd_word[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wcnt_d    = wcnt_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    mem_we    = '0;
    mem_widx  = req_q.idx;
    mem_wdata = req_q.wdata;

    unique case (state_q)
      S_CLEAR: begin
        mem_we    = '1;
        mem_widx  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.idx   = req_addr[ADDR_WIDTH+1:2];
          req_d.be    = req_be;
          req_d.wdata = req_wdata;
          req_d.err   = (req_addr[31:ADDR_WIDTH+2] != '0) | (req_be == '0);
          wcnt_d      = WAIT_INIT;
          rdata_d     = '0;
          rerr_d      = 1'b0;
          state_d     = (WAIT_INIT != '0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        // Leave on the cycle the count sits at 1 so WAIT lasts WAIT_CYCLES cycles;
        // the <= guard keeps a zero count from wrapping.
        if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (req_q.we && !req_q.err) mem_we = req_q.be;
        rdata_d = (!req_q.we && !req_q.err) ? rd_word : '0;
        rerr_d  = req_q.err;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    // Reset abandons any in-flight access, including a store about to commit.
    if (!rst) begin
      state_d   = S_CLEAR;
      clr_idx_d = '0;
      wcnt_d    = '0;
      req_d     = '0;
      rdata_d   = '0;
      rerr_d    = 1'b0;
      mem_we    = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    wcnt_q    <= wcnt_d;
    req_q     <= req_d;
    rdata_q   <= rdata_d;
    rerr_q    <= rerr_d;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset sweep, store/load, byte lanes,
// backpressure, error requests and reset during a pending store.

module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issues one request, checks latency/data/err; hold>0 keeps resp_ready low
  // that many RESP cycles and pokes req_valid meanwhile, which must be ignored.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err);
    int w;
    int lat;
    w = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    resp_ready = (hold == 0);
    while (!req_ready && w < 2000) begin tick(); w++; end
    if (!req_ready) chk({tag, "_rdy_timeout"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin tick(); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_be = 4'hF; req_wdata = 32'h0;
      end
      tick();
      chk({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_bp_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_bp_busy"}, 32'(busy), 32'd1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    if (hold > 0) begin
      chk({tag, "_post_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    int idle_seen;
    n = 0;
    idle_seen = 0;
    while (!req_ready && n < 2000) begin
      if (!busy) idle_seen++;
      tick();
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'd1024);
    chk({tag, "_busy_drop"}, 32'(idle_seen), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; resp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    wait_sweep("sweep");

    do_req("ld0",    1'b0, 32'h0000_0000, 4'hF, 32'h0,         0, 32'h0,         1'b0);
    do_req("st4",    1'b1, 32'h0000_0004, 4'hF, 32'hDEADBEEF,  0, 32'h0,         1'b0);
    do_req("ld4",    1'b0, 32'h0000_0004, 4'hF, 32'h0,         0, 32'hDEADBEEF,  1'b0);
    do_req("st4b1",  1'b1, 32'h0000_0004, 4'h2, 32'h0000AA00,  0, 32'h0,         1'b0);
    do_req("ld4b1",  1'b0, 32'h0000_0004, 4'hF, 32'h0,         0, 32'hDEADAAEF,  1'b0);
    do_req("bp",     1'b0, 32'h0000_0004, 4'hF, 32'h0,         5, 32'hDEADAAEF,  1'b0);
    do_req("ld4chk", 1'b0, 32'h0000_0004, 4'hF, 32'h0,         0, 32'hDEADAAEF,  1'b0);
    do_req("ld_oob", 1'b0, 32'h0000_1000, 4'hF, 32'h0,         0, 32'h0,         1'b1);
    do_req("st_be0", 1'b1, 32'h0000_0008, 4'h0, 32'h12345678,  0, 32'h0,         1'b1);
    do_req("ld8",    1'b0, 32'h0000_0008, 4'hF, 32'h0,         0, 32'h0,         1'b0);

    // Store accepted, then reset lands in the first WAIT cycle.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
    chk("mid_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("mid_wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    wait_sweep("sweep2");
    do_req("ldC", 1'b0, 32'h0000_000C, 4'hF, 32'h0, 0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
